// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller FSM encoding, the NOP used for flush/bubble, next-PC selectors.
package pipeline_ctrl_pkg;

  // Controller FSM: normal flow or frozen behind a multi-cycle MDU op.
  typedef enum logic [0:0] {
    PCTL_RUN      = 1'b0,
    PCTL_MDU_WAIT = 1'b1
  } pctl_state_t;

  // Instruction loaded by a flushed or bubbled pipeline register (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Next-PC source selectors, also decoded by the hazard unit.
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JALR   = 2'd2;
  localparam logic [1:0] NPC_HOLD   = 2'd3;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Wrapping event counter for performance statistics.
// Latency: count updates at the clock edge where inc is high.
// Backpressure: none; wraps modulo 2^CNT_W, never saturates.
// Ports: clk, rst (sync, active-high), inc (count enable), cnt (current value).
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Turns load-use stall, EX rollback and MDU busy into pipeline-register enables/flushes/bubbles.
// Latency: enables/flush/bubble are combinational; valid bits, counters and flags are registered.
// Backpressure: holds PC/IF/ID on load-use, freezes the front end (PC..ID/EX) for the whole MDU wait.
// Ports: clk/rst; hazard inputs ctrlStall, rollback_IF_ID_EX, mduStart, mduDone;
//        register controls pcWrite..exMemBubble; stage valids v_*; perf counters; sticky flags.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrlStall,
  input  logic             rollback_IF_ID_EX,
  input  logic             mduStart,
  input  logic             mduDone,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExWrite,
  output logic             idExBubble,
  output logic             exMemBubble,
  output logic             v_IF_ID,
  output logic             v_ID_EX,
  output logic             v_EX_MEM,
  output logic             v_MEM_WB,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] retireCnt,
  output logic             mduTimeout,
  output logic             protoErr
);

  localparam int WD_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  pctl_state_t     state, state_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            v_if_id_nxt, v_id_ex_nxt, v_ex_mem_nxt, v_mem_wb_nxt;
  logic            lu_stall, rb, mdu, wd_expired;
  logic            stall_inc, flush_inc, timeout_set, proto_set;

  // Hazards raised against a bubble in ID/EX are meaningless and must not act.
  assign lu_stall   = ctrlStall & v_ID_EX;
  assign rb         = rollback_IF_ID_EX & v_ID_EX;
  assign mdu        = mduStart & v_ID_EX;
  assign wd_expired = (wd == WD_LAST);

  always_comb begin
    // Defaults describe a normal advancing cycle.
    pcWrite      = 1'b1;
    ifIdWrite    = 1'b1;
    ifIdFlush    = 1'b0;
    idExWrite    = 1'b1;
    idExBubble   = 1'b0;
    exMemBubble  = 1'b0;
    state_nxt    = state;
    wd_nxt       = wd;
    v_if_id_nxt  = 1'b1;
    v_id_ex_nxt  = v_IF_ID;
    v_ex_mem_nxt = v_ID_EX;
    v_mem_wb_nxt = v_EX_MEM;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    timeout_set  = 1'b0;
    proto_set    = 1'b0;

    if (!rst) begin
      unique case (state)
        PCTL_RUN: begin
          if (rb) begin
            // Redirect: wrong-path IF/ID and ID/EX contents are squashed,
            // the branch itself keeps moving into MEM.
            ifIdFlush   = 1'b1;
            idExBubble  = 1'b1;
            v_id_ex_nxt = 1'b0;
            flush_inc   = 1'b1;
          end else if (mdu && !mduDone) begin
            // Single-cycle MDU completion needs no freeze.
            pcWrite      = 1'b0;
            ifIdWrite    = 1'b0;
            idExWrite    = 1'b0;
            exMemBubble  = 1'b1;
            v_if_id_nxt  = v_IF_ID;
            v_id_ex_nxt  = v_ID_EX;
            v_ex_mem_nxt = 1'b0;
            state_nxt    = PCTL_MDU_WAIT;
            wd_nxt       = '0;
          end else if (lu_stall) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExBubble  = 1'b1;
            v_if_id_nxt = v_IF_ID;
            v_id_ex_nxt = 1'b0;
            stall_inc   = 1'b1;
          end
        end

        PCTL_MDU_WAIT: begin
          // The front end is frozen, so a rollback here means the hazard
          // unit broke protocol; it is ignored but recorded.
          proto_set = rollback_IF_ID_EX;
          if (mduDone || wd_expired) begin
            timeout_set = !mduDone;
            state_nxt   = PCTL_RUN;
          end else begin
            pcWrite      = 1'b0;
            ifIdWrite    = 1'b0;
            idExWrite    = 1'b0;
            exMemBubble  = 1'b1;
            v_if_id_nxt  = v_IF_ID;
            v_id_ex_nxt  = v_ID_EX;
            v_ex_mem_nxt = 1'b0;
            wd_nxt       = wd + WD_W'(1);
          end
        end

        default: begin
          state_nxt = PCTL_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PCTL_RUN;
      wd         <= '0;
      v_IF_ID    <= 1'b0;
      v_ID_EX    <= 1'b0;
      v_EX_MEM   <= 1'b0;
      v_MEM_WB   <= 1'b0;
      mduTimeout <= 1'b0;
      protoErr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wd       <= wd_nxt;
      v_IF_ID  <= v_if_id_nxt;
      v_ID_EX  <= v_id_ex_nxt;
      v_EX_MEM <= v_ex_mem_nxt;
      v_MEM_WB <= v_mem_wb_nxt;
      if (timeout_set) begin
        mduTimeout <= 1'b1;
      end
      if (proto_set) begin
        protoErr <= 1'b1;
      end
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stallCnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flushCnt)
  );

  // An instruction retires whenever MEM/WB holds a valid one at an edge.
  perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .inc (v_MEM_WB),
    .cnt (retireCnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic
// compared against a stage-occupancy model of the pipeline kept in the bench.
module tb_pipeline_ctrl;

  localparam int CW  = 4;
  localparam int TO  = 12;
  localparam int MOD = 1 << CW;

  localparam int A_NORM = 0;
  localparam int A_RB   = 1;
  localparam int A_FRZ  = 2;
  localparam int A_STL  = 3;

  // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble}
  localparam logic [5:0] C_NORM = 6'b110100;
  localparam logic [5:0] C_RB   = 6'b111110;
  localparam logic [5:0] C_FRZ  = 6'b000001;
  localparam logic [5:0] C_STL  = 6'b000110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ctrlStall = 1'b0, rollback_IF_ID_EX = 1'b0, mduStart = 1'b0, mduDone = 1'b0;
  logic pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble;
  logic v_IF_ID, v_ID_EX, v_EX_MEM, v_MEM_WB;
  logic [CW-1:0] stallCnt, flushCnt, retireCnt;
  logic mduTimeout, protoErr;

  pipeline_ctrl #(.CNT_W(CW), .MDU_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .ctrlStall         (ctrlStall),
    .rollback_IF_ID_EX (rollback_IF_ID_EX),
    .mduStart          (mduStart),
    .mduDone           (mduDone),
    .pcWrite           (pcWrite),
    .ifIdWrite         (ifIdWrite),
    .ifIdFlush         (ifIdFlush),
    .idExWrite         (idExWrite),
    .idExBubble        (idExBubble),
    .exMemBubble       (exMemBubble),
    .v_IF_ID           (v_IF_ID),
    .v_ID_EX           (v_ID_EX),
    .v_EX_MEM          (v_EX_MEM),
    .v_MEM_WB          (v_MEM_WB),
    .stallCnt          (stallCnt),
    .flushCnt          (flushCnt),
    .retireCnt         (retireCnt),
    .mduTimeout        (mduTimeout),
    .protoErr          (protoErr)
  );

  wire [5:0]      ctl_obs = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble};
  wire [3:0]      v_obs   = {v_IF_ID, v_ID_EX, v_EX_MEM, v_MEM_WB};
  wire [3*CW+1:0] st_obs  = {stallCnt, flushCnt, retireCnt, mduTimeout, protoErr};

  int total = 0;
  int bad   = 0;

  // Reference model: occupancy of the four stage slots plus counters/flags.
  bit         mv[4];      // 0=IF/ID .. 3=MEM/WB
  bit         m_wait;
  int         m_wc;
  int         m_st, m_fl, m_rt;
  bit         m_to, m_pe;
  int         act;
  logic [5:0] ctl_exp;

  function automatic logic [3:0] v_exp();
    return {mv[0], mv[1], mv[2], mv[3]};
  endfunction

  function automatic logic [3*CW+1:0] st_exp();
    return {CW'(m_st), CW'(m_fl), CW'(m_rt), m_to, m_pe};
  endfunction

  // Drive one cycle's inputs, predict its combinational outputs, stop at the negedge.
  task automatic apply(input bit r, input bit s, input bit b, input bit ms, input bit md);
    rst = r; ctrlStall = s; rollback_IF_ID_EX = b; mduStart = ms; mduDone = md;
    if (r) act = A_NORM;
    else if (m_wait) act = (md || m_wc == TO - 1) ? A_NORM : A_FRZ;
    else if (b && mv[1]) act = A_RB;
    else if (ms && mv[1] && !md) act = A_FRZ;
    else if (s && mv[1]) act = A_STL;
    else act = A_NORM;
    case (act)
      A_RB:    ctl_exp = C_RB;
      A_FRZ:   ctl_exp = C_FRZ;
      A_STL:   ctl_exp = C_STL;
      default: ctl_exp = C_NORM;
    endcase
    @(negedge clk);
  endtask

  // Take the clock edge and move the model along with it.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      foreach (mv[i]) mv[i] = 1'b0;
      m_wait = 0; m_wc = 0; m_st = 0; m_fl = 0; m_rt = 0; m_to = 0; m_pe = 0;
    end else begin
      if (mv[3]) m_rt = (m_rt + 1) % MOD;
      if (m_wait && rollback_IF_ID_EX) m_pe = 1;
      case (act)
        A_RB: begin
          mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = 0; mv[0] = 1;
          m_fl = (m_fl + 1) % MOD;
        end
        A_STL: begin
          mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = 0;
          m_st = (m_st + 1) % MOD;
        end
        A_FRZ: begin
          mv[3] = mv[2]; mv[2] = 0;
          if (m_wait) m_wc++;
          else begin m_wait = 1; m_wc = 0; end
        end
        default: begin
          if (m_wait && !mduDone) m_to = 1;
          m_wait = 0;
          mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = mv[0]; mv[0] = 1;
        end
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 0);
    total++;
    if (ctl_obs !== C_NORM) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl_obs, C_NORM); end
    advance();
    apply(1, 0, 0, 0, 0);
    advance();
    apply(0, 0, 0, 0, 0);
    total++;
    if (v_obs !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b want 0000", v_obs); end
    total++;
    if (st_obs !== '0) begin bad++; $display("FAIL reset_cnt_flags: got %h want 0", st_obs); end
    advance();
  endtask

  task automatic test_normal();
    // One normal edge already happened at the end of test_reset.
    for (int e = 1; e <= 6; e++) begin
      apply(0, 0, 0, 0, 0);
      total++;
      if (ctl_obs !== C_NORM) begin bad++; $display("FAIL normal_ctl e=%0d: got %b want %b", e, ctl_obs, C_NORM); end
      total++;
      if (v_MEM_WB !== (e >= 4)) begin bad++; $display("FAIL normal_vmemwb e=%0d: got %b want %b", e, v_MEM_WB, (e >= 4)); end
      total++;
      if (retireCnt !== CW'((e > 4) ? e - 4 : 0)) begin
        bad++; $display("FAIL normal_retire e=%0d: got %0d want %0d", e, retireCnt, (e > 4) ? e - 4 : 0);
      end
      total++;
      if (v_obs !== v_exp()) begin bad++; $display("FAIL normal_valid e=%0d: got %b want %b", e, v_obs, v_exp()); end
      advance();
    end
  endtask

  task automatic test_stall();
    apply(0, 1, 0, 0, 0);
    total++;
    if (ctl_obs !== C_STL) begin bad++; $display("FAIL stall_ctl: got %b want %b", ctl_obs, C_STL); end
    advance();
    // ID/EX now holds a bubble: the same request must be ignored.
    apply(0, 1, 0, 0, 0);
    total++;
    if (v_ID_EX !== 1'b0) begin bad++; $display("FAIL stall_bubble: got %b want 0", v_ID_EX); end
    total++;
    if (stallCnt !== CW'(1)) begin bad++; $display("FAIL stall_cnt: got %0d want 1", stallCnt); end
    total++;
    if (ctl_obs !== C_NORM) begin bad++; $display("FAIL stall_on_bubble_ctl: got %b want %b", ctl_obs, C_NORM); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++;
    if (stallCnt !== CW'(1)) begin bad++; $display("FAIL stall_cnt_hold: got %0d want 1", stallCnt); end
    advance();
  endtask

  task automatic test_rb_stall();
    logic [CW-1:0] st_before;
    st_before = CW'(m_st);
    apply(0, 1, 1, 0, 0);
    total++;
    if (ctl_obs !== C_RB) begin bad++; $display("FAIL rb_ctl: got %b want %b", ctl_obs, C_RB); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++;
    if (flushCnt !== CW'(1)) begin bad++; $display("FAIL rb_flushcnt: got %0d want 1", flushCnt); end
    total++;
    if (stallCnt !== st_before) begin bad++; $display("FAIL rb_stallcnt: got %0d want %0d", stallCnt, st_before); end
    total++;
    if ({v_IF_ID, v_ID_EX} !== 2'b10) begin bad++; $display("FAIL rb_valid: got %b want 10", {v_IF_ID, v_ID_EX}); end
    advance();
  endtask

  task automatic test_mdu_done();
    apply(0, 0, 0, 0, 0);
    advance();
    apply(0, 0, 0, 1, 0);
    total++;
    if (ctl_obs !== C_FRZ) begin bad++; $display("FAIL mdu_start_ctl: got %b want %b", ctl_obs, C_FRZ); end
    advance();
    for (int i = 1; i <= 9; i++) begin
      apply(0, i % 2 == 0, i == 3, 0, 0);
      total++;
      if (ctl_obs !== C_FRZ) begin bad++; $display("FAIL mdu_wait_ctl i=%0d: got %b want %b", i, ctl_obs, C_FRZ); end
      total++;
      if (v_EX_MEM !== 1'b0) begin bad++; $display("FAIL mdu_wait_vexmem i=%0d: got %b want 0", i, v_EX_MEM); end
      advance();
    end
    apply(0, 0, 0, 0, 1);
    total++;
    if (ctl_obs !== C_NORM) begin bad++; $display("FAIL mdu_done_ctl: got %b want %b", ctl_obs, C_NORM); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++;
    if (ctl_obs !== C_NORM) begin bad++; $display("FAIL mdu_back_to_run: got %b want %b", ctl_obs, C_NORM); end
    total++;
    if ({mduTimeout, protoErr} !== 2'b01) begin bad++; $display("FAIL mdu_flags: got %b want 01", {mduTimeout, protoErr}); end
    total++;
    if (st_obs !== st_exp()) begin bad++; $display("FAIL mdu_counters: got %h want %h", st_obs, st_exp()); end
    advance();
  endtask

  task automatic test_mdu_timeout();
    int n;
    apply(0, 0, 0, 1, 0);
    n = 0;
    while (ctl_obs == C_FRZ && n < 50) begin
      n++;
      advance();
      apply(0, 0, 0, 0, 0);
    end
    total++;
    if (n !== TO) begin bad++; $display("FAIL timeout_frozen_cycles: got %0d want %0d", n, TO); end
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0);
      total++;
      if (mduTimeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky i=%0d: got %b want 1", i, mduTimeout); end
      advance();
    end
  endtask

  task automatic test_wrap_and_reset();
    int guard;
    guard = 0;
    while (m_st != MOD - 1 && guard < 100) begin
      guard++;
      apply(0, 1, 0, 0, 0);
      advance();
      apply(0, 0, 0, 0, 0);
      advance();
    end
    apply(0, 1, 0, 0, 0);
    total++;
    if (stallCnt !== CW'(MOD - 1)) begin bad++; $display("FAIL wrap_pre: got %0d want %0d", stallCnt, MOD - 1); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++;
    if (stallCnt !== '0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", stallCnt); end
    advance();
    // Enter MDU_WAIT and reset from inside it.
    apply(0, 0, 0, 1, 0);
    advance();
    apply(0, 0, 0, 0, 0);
    total++;
    if (ctl_obs !== C_FRZ) begin bad++; $display("FAIL rst_wait_entered: got %b want %b", ctl_obs, C_FRZ); end
    advance();
    apply(1, 0, 0, 0, 0);
    total++;
    if (ctl_obs !== C_NORM) begin bad++; $display("FAIL rst_wait_ctl: got %b want %b", ctl_obs, C_NORM); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++;
    if (ctl_obs !== C_NORM) begin bad++; $display("FAIL rst_wait_state: got %b want %b", ctl_obs, C_NORM); end
    total++;
    if ({st_obs, v_obs} !== '0) begin bad++; $display("FAIL rst_wait_regs: got %h want 0", {st_obs, v_obs}); end
    advance();
  endtask

  task automatic test_random();
    bit r, s, b, ms, md;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      s  = $urandom_range(0, 1) == 1;
      b  = ($urandom_range(0, 3) == 0);
      ms = ($urandom_range(0, 4) == 0);
      md = ($urandom_range(0, 7) == 0);
      apply(r, s, b, ms, md);
      total++;
      if (ctl_obs !== ctl_exp) begin bad++; $display("FAIL rand_ctl i=%0d: got %b want %b", i, ctl_obs, ctl_exp); end
      total++;
      if (v_obs !== v_exp()) begin bad++; $display("FAIL rand_valid i=%0d: got %b want %b", i, v_obs, v_exp()); end
      total++;
      if (st_obs !== st_exp()) begin bad++; $display("FAIL rand_cnt_flags i=%0d: got %h want %h", i, st_obs, st_exp()); end
      advance();
    end
  endtask

  initial begin
    foreach (mv[i]) mv[i] = 1'b0;
    m_wait = 0; m_wc = 0; m_st = 0; m_fl = 0; m_rt = 0; m_to = 0; m_pe = 0;
    act = A_NORM; ctl_exp = C_NORM;
    test_reset();
    test_normal();
    test_stall();
    test_rb_stall();
    test_mdu_done();
    test_mdu_timeout();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
